// File: rtl/timer_irq_gen_pkg.sv
// Shared timer/counter definitions: register word offsets, CTRL bit positions,
// FSM state encodings and mode codes (same values CP0 decodes).
package timer_irq_gen_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int _TC_EN   = 0;
  localparam int _TC_MODE = 1;
  localparam int _TC_IM   = 3;

  localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  // Codes 1x fall back to one-shot.
  function automatic logic tc_is_reload(input logic [1:0] mode);
    return (mode == TC_MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_irq_gen.sv
// Countdown timer raising one HWInt line; enable-to-irq latency PRESET+2 cycles.
// Bus writes take effect at the sampling edge with no stall; reads are combinational.
module timer_irq_gen
  import timer_irq_gen_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic [3:0]       ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             irq_flag;
  tc_state_e        state;

  logic       en;
  logic [1:0] mode;
  logic       im;

  assign en   = ctrl_q[_TC_EN];
  assign mode = ctrl_q[_TC_MODE +: 2];
  assign im   = ctrl_q[_TC_IM];
  assign irq  = irq_flag & im;

  always_comb begin
    dout = '0;
    case (addr)
      TC_CTRL:   dout = {28'd0, ctrl_q};
      TC_PRESET: dout = 32'(preset_q);
      TC_COUNT:  dout = 32'(count_q);
      default:   dout = '0;
    endcase
  end

  // Bus writes are applied after the FSM so a CTRL write overrides both the
  // one-shot EN clear and a same-edge irq_flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_flag <= 1'b0;
      state    <= TC_IDLE;
    end else begin
      case (state)
        TC_IDLE: begin
          if (en) state <= TC_LOAD;
        end
        TC_LOAD: begin
          count_q <= preset_q;
          state   <= TC_CNT;
        end
        TC_CNT: begin
          if (!en) begin
            state <= TC_IDLE;
          end else if (count_q <= CNT_W'(1)) begin
            count_q  <= '0;
            irq_flag <= 1'b1;
            state    <= TC_INT;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        TC_INT: begin
          if (tc_is_reload(mode)) begin
            irq_flag <= 1'b0;
            state    <= TC_LOAD;
          end else begin
            ctrl_q[_TC_EN] <= 1'b0;
            state          <= TC_IDLE;
          end
        end
        default: state <= TC_IDLE;
      endcase

      if (we && addr == TC_CTRL) begin
        ctrl_q   <= din[3:0];
        irq_flag <= 1'b0;
      end
      if (we && addr == TC_PRESET) begin
        preset_q <= din[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_timer_irq_gen.sv
// Directed and randomized checks of timer_irq_gen against an arithmetic
// schedule of expected interrupt edges.
module tb_timer_irq_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int errors = 0;
  int checks = 0;

  timer_irq_gen #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Timer treats a preset of 0 as 1.
  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  // Auto-reload run: preset p1, then preset p2 written at edge wr_c.
  // Pulse edges: first at 2+eff(p1); each reload samples PRESET two edges after
  // a pulse, using the new value only if it was written at an earlier edge.
  task automatic reload_run(input string tag, input int p1, input int p2, input int wr_c);
    logic exp_pulse [0:40];
    int t, ld, p;
    for (int i = 0; i <= 40; i++) exp_pulse[i] = 1'b0;
    t = 2 + eff(p1);
    while (t <= 40) begin
      exp_pulse[t] = 1'b1;
      ld = t + 2;
      p  = (ld > wr_c) ? p2 : p1;
      t  = ld + eff(p);
    end
    do_reset();
    wr(2'd1, 32'(p1));
    wr(2'd0, 32'hB);
    for (int c = 1; c <= 40; c++) begin
      if (c == wr_c) begin
        addr = 2'd1; din = 32'(p2); we = 1'b1;
      end
      tick();
      we = 1'b0;
      chk($sformatf("%s irq@E%0d", tag, c), {31'd0, irq}, {31'd0, exp_pulse[c]});
    end
  endtask

  initial begin
    logic [31:0] v;
    int p, n;

    // Reset state
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk($sformatf("reset dout[%0d]", a), v, 32'd0);
    end
    chk("reset irq", {31'd0, irq}, 32'd0);

    // One-shot P=5 with IM
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);                      // E0
    tick(); tick();                       // E2
    rd(2'd2, v); chk("os count@E2", v, 32'd5);
    repeat (4) tick();                    // E6
    rd(2'd2, v); chk("os count@E6", v, 32'd1);
    chk("os irq@E6", {31'd0, irq}, 32'd0);
    tick();                               // E7
    rd(2'd2, v); chk("os count@E7", v, 32'd0);
    chk("os irq@E7", {31'd0, irq}, 32'd1);
    tick();                               // E8
    rd(2'd0, v); chk("os ctrl@E8", v, 32'h8);
    chk("os irq@E8", {31'd0, irq}, 32'd1);
    repeat (3) tick();
    chk("os irq held", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h8);
    chk("os irq ack", {31'd0, irq}, 32'd0);
    tick();
    chk("os irq stays low", {31'd0, irq}, 32'd0);

    // Auto-reload P=5, PRESET=2 written during second period
    reload_run("ar5to2", 5, 2, 10);

    // Randomized auto-reload runs
    for (int r = 0; r < 3; r++)
      reload_run($sformatf("arr%0d", r), $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(1, 30));

    // Randomized one-shot latency
    for (int r = 0; r < 3; r++) begin
      p = $urandom_range(0, 8);
      n = eff(p) + 2;
      do_reset();
      wr(2'd1, 32'(p));
      wr(2'd0, 32'h9);
      for (int c = 1; c <= n + 2; c++) begin
        tick();
        chk($sformatf("osr%0d p%0d irq@E%0d", r, p, c), {31'd0, irq}, {31'd0, c >= n});
      end
      rd(2'd0, v); chk($sformatf("osr%0d ctrl", r), v, 32'h8);
    end

    // Disable mid-count: count freezes, re-enable reloads
    do_reset();
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h1);                      // E0
    repeat (4) tick();                    // E4: count 4
    wr(2'd0, 32'h0);                      // E5: count 3, EN cleared
    rd(2'd2, v); chk("dis count@E5", v, 32'd3);
    repeat (4) tick();
    rd(2'd2, v); chk("dis count held", v, 32'd3);
    chk("dis irq", {31'd0, irq}, 32'd0);
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);                      // E0'
    tick();
    rd(2'd2, v); chk("reen count@E1", v, 32'd3);
    tick();
    rd(2'd2, v); chk("reen count@E2", v, 32'd5);

    // PRESET=0 with IM: irq at E3
    do_reset();
    wr(2'd0, 32'h9);
    tick(); tick();
    chk("p0 irq@E2", {31'd0, irq}, 32'd0);
    tick();
    chk("p0 irq@E3", {31'd0, irq}, 32'd1);

    // PRESET=0 with IM=0: irq stays low; setting IM via CTRL clears the flag
    do_reset();
    wr(2'd0, 32'h1);
    repeat (5) tick();
    chk("p0 nomask irq", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h8);
    chk("p0 im set irq", {31'd0, irq}, 32'd0);
    tick();
    chk("p0 im set irq later", {31'd0, irq}, 32'd0);

    // CTRL write at the edge the FSM sets irq_flag: flag ends cleared
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);                      // E0
    repeat (3) tick();                    // E3
    wr(2'd0, 32'h9);                      // E4: flag set vs CTRL write
    chk("coll flag irq", {31'd0, irq}, 32'd0);
    tick();                               // E5: INT clears EN
    rd(2'd0, v); chk("coll flag ctrl", v, 32'h8);

    // CTRL write at the edge one-shot INT clears EN: bus value wins
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);                      // E0
    repeat (4) tick();                    // E4: flag set
    chk("coll en irq@E4", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'hB);                      // E5
    rd(2'd0, v); chk("coll en ctrl", v, 32'hB);
    chk("coll en irq", {31'd0, irq}, 32'd0);

    // Reset mid-count
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (4) tick();
    do_reset();
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      chk($sformatf("midrst dout[%0d]", a), v, 32'd0);
    end
    chk("midrst irq", {31'd0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
